activity_timer_ctrl: RTL

//  Sequences a one-second timebase to measure high-activity time for the step tracker.

---
 rtl/act_timer_pkg.sv | 22 ++
 rtl/sec_prescaler.sv | 33 +++
 rtl/activity_timer_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/act_timer_pkg.sv
// Shared definitions for the activity timer: FSM state encoding, counter width
// and a saturating adder used by the consecutive-window and total counters.
package act_timer_pkg;

    localparam int CONSEC_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_MEASURE = 2'd1;
    localparam state_t ST_ACTIVE  = 2'd2;

    // Sum is formed one bit wider than the operands so it can never wrap before the clamp.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second timebase: counts 0..CLK_PER_SEC-1 while run is high, held at 0 otherwise.
// tick marks the last cycle of each window.
module sec_prescaler #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic run,
    output logic tick
);

    localparam int                CNT_W    = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnt <= '0;
        end else if (!run || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = run && w_at_last;

endmodule

// File: rtl/activity_timer_ctrl.sv
// Activity timer: classifies 1 s windows by step count and credits sustained activity.
// Optional build macro ACT_TIMER_LAST_WIN_EN adds the LAST_WIN_STEPS output.
module activity_timer_ctrl
    import act_timer_pkg::*;
#(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int STEP_THRESH = 2,
    parameter int ARM_SECS    = 60,
    parameter int TOT_W       = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic                STEP,
    input  logic                CLEAR,
    output logic                SEC_TICK,
    output logic [CONSEC_W-1:0] CONSEC_SECS,
    output logic [TOT_W-1:0]    ACTIVE_SECS,
    output logic                HIGH_ACT,
    output logic [1:0]          STATE
`ifdef ACT_TIMER_LAST_WIN_EN
    ,
    output logic [7:0]          LAST_WIN_STEPS
`endif
);

    localparam int              SC_W       = $clog2(STEP_THRESH + 1);
    localparam logic [SC_W-1:0] SC_MAX     = SC_W'(STEP_THRESH);
    localparam logic [SC_W:0]   THRESH_V   = (SC_W + 1)'(STEP_THRESH);
    localparam logic [31:0]     TOT_MAX    = 32'((64'd1 << TOT_W) - 64'd1);
    localparam logic [31:0]     CONSEC_MAX = 32'((1 << CONSEC_W) - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [SC_W-1:0]       r_step_cnt;
    logic [CONSEC_W-1:0]   r_consec;
    logic [TOT_W-1:0]      r_total;

    logic                  w_run;
    logic                  w_tick;
    logic [SC_W:0]         w_win_steps;
    logic                  w_win_active;
    logic [CONSEC_W-1:0]   w_consec_inc;
    logic                  w_arm_hit;
    logic [TOT_W-1:0]      w_total_arm;
    logic [TOT_W-1:0]      w_total_one;

    assign w_run = ENABLE && (r_state != ST_IDLE);

    sec_prescaler #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_sec_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .run   (w_run),
        .tick  (w_tick)
    );

    // A step landing on the tick cycle still belongs to the window that is ending.
    assign w_win_steps  = {1'b0, r_step_cnt} + {{SC_W{1'b0}}, STEP};
    assign w_win_active = (w_win_steps >= THRESH_V);

    assign w_consec_inc = CONSEC_W'(sat_add(32'(r_consec), 32'd1, CONSEC_MAX));
    assign w_arm_hit    = (w_consec_inc == CONSEC_W'(ARM_SECS));
    assign w_total_arm  = TOT_W'(sat_add(32'(r_total), 32'(ARM_SECS), TOT_MAX));
    assign w_total_one  = TOT_W'(sat_add(32'(r_total), 32'd1, TOT_MAX));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_step_cnt <= '0;
        end else if (!w_run || w_tick) begin
            r_step_cnt <= '0;
        end else if (STEP && (r_step_cnt != SC_MAX)) begin
            r_step_cnt <= r_step_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_next_state = r_state;
        if (CLEAR) begin
            w_next_state = ENABLE ? ST_MEASURE : ST_IDLE;
        end else if (!ENABLE) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (w_tick && w_win_active && w_arm_hit) begin
                        w_next_state = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_tick && !w_win_active) begin
                        w_next_state = ST_MEASURE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        HIGH_ACT = (r_state == ST_ACTIVE);
        STATE    = r_state;
    end

    // Reaching the arming count credits the whole qualifying streak at once.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_consec <= '0;
            r_total  <= '0;
        end else if (CLEAR) begin
            r_consec <= '0;
            r_total  <= '0;
        end else if (!ENABLE) begin
            r_consec <= '0;
        end else if (w_tick) begin
            if (!w_win_active) begin
                r_consec <= '0;
            end else begin
                r_consec <= w_consec_inc;
                case (r_state)
                    ST_MEASURE: begin
                        if (w_arm_hit) begin
                            r_total <= w_total_arm;
                        end
                    end
                    ST_ACTIVE: begin
                        r_total <= w_total_one;
                    end
                    default: begin
                        r_total <= r_total;
                    end
                endcase
            end
        end
    end

    assign SEC_TICK    = w_tick;
    assign CONSEC_SECS = r_consec;
    assign ACTIVE_SECS = r_total;

`ifdef ACT_TIMER_LAST_WIN_EN
    logic [7:0] r_win_steps8;
    logic [7:0] r_last_win;
    logic [7:0] w_win_steps8_inc;

    assign w_win_steps8_inc = (STEP && (r_win_steps8 != 8'hFF)) ? r_win_steps8 + 8'd1 : r_win_steps8;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_win_steps8 <= '0;
            r_last_win   <= '0;
        end else if (!ENABLE) begin
            r_win_steps8 <= '0;
            r_last_win   <= '0;
        end else if (w_tick) begin
            r_win_steps8 <= '0;
            r_last_win   <= w_win_steps8_inc;
        end else if (w_run) begin
            r_win_steps8 <= w_win_steps8_inc;
        end else begin
            r_win_steps8 <= '0;
        end
    end

    assign LAST_WIN_STEPS = r_last_win;
`endif

endmodule
